// File: rtl/vpu_reset_sequencer.sv
// vpu_reset_sequencer
//   Staggered reset sequencer for the VPU sub-blocks. After the system reset
//   (or an accepted soft-reset request) all targeted channels are held low for
//   HOLD_CYCLES edges. They are then released one at a time in ascending index
//   order, STAGGER_CYCLES edges apart.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   sw_rst_req_i  soft-reset request (level, held until ack)
//   ch_mask_i     channels targeted by the soft reset, sampled on accept
//   sw_rst_ack_o  1-cycle accept pulse (also issued for a zero mask)
//   ch_rst_n_o    per-channel active-low resets
//   seq_busy_o    hold/release in progress
//   seq_done_o    1-cycle pulse on the final release
//   ch_ready_i    [VPU_RST_SEQ_READY_WAIT_EN] channel out-of-reset status
//   seq_err_o     [VPU_RST_SEQ_READY_WAIT_EN] sticky ready-timeout flag
//
// Optional feature macro: VPU_RST_SEQ_READY_WAIT_EN
//   When defined, each release also waits for ch_ready_i of the previously
//   released channel, bounded by WDOG_CYCLES edges.
module vpu_reset_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int WDOG_CYCLES    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_rst_req_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  output logic              sw_rst_ack_o,
  output logic [NUM_CH-1:0] ch_rst_n_o,
  output logic              seq_busy_o,
  output logic              seq_done_o
`ifdef VPU_RST_SEQ_READY_WAIT_EN
  ,
  input  logic [NUM_CH-1:0] ch_ready_i,
  output logic              seq_err_o
`endif
);

  localparam int MAX_HS = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int MAX_C  = (MAX_HS > WDOG_CYCLES) ? MAX_HS : WDOG_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] HOLD_C  = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] STAG_C  = CW'(STAGGER_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] rstn_d;
  logic [NUM_CH-1:0] pend, low, rest;
  logic              busy_d, ack_d, done_d;
  logic              rel, fin, adv;

`ifdef VPU_RST_SEQ_READY_WAIT_EN
  localparam logic [CW-1:0] WDOG_C = CW'(WDOG_CYCLES);
  logic [NUM_CH-1:0] last_q, last_d;
  logic              err_d, ready_hit;
`endif

  // Saturating edge counter; never wraps.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Channels still waiting for release are the masked ones still held low;
  // taking the lowest set bit skips unmasked channels in zero time.
  assign pend = mask_q & ~ch_rst_n_o;
  assign low  = pend & (~pend + NUM_CH'(1));
  assign rest = pend & ~low;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    mask_d  = mask_q;
    rstn_d  = ch_rst_n_o;
    busy_d  = seq_busy_o;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    rel     = 1'b0;
    fin     = 1'b0;
    adv     = 1'b0;
`ifdef VPU_RST_SEQ_READY_WAIT_EN
    err_d     = seq_err_o;
    last_d    = last_q;
    ready_hit = |(ch_ready_i & last_q);
`endif

    case (state_q)
      IDLE: begin
        // The edge right after an ack ignores req so a requester dropping it
        // one cycle late is not taken as a second request.
        if (sw_rst_req_i && !sw_rst_ack_o) begin
          ack_d  = 1'b1;
          mask_d = ch_mask_i;
          if (|ch_mask_i) begin
            rstn_d  = ch_rst_n_o & ~ch_mask_i;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = HOLD;
`ifdef VPU_RST_SEQ_READY_WAIT_EN
            err_d   = 1'b0;
`endif
          end
        end
      end
      HOLD: begin
        rel = (cnt_inc >= HOLD_C);
      end
      RELEASE: begin
        adv = (cnt_inc >= STAG_C);
`ifdef VPU_RST_SEQ_READY_WAIT_EN
        adv = adv && (ready_hit || (cnt_inc >= WDOG_C));
        if (adv && !ready_hit) err_d = 1'b1;
`endif
        if (adv) begin
          if (pend == '0) fin = 1'b1;
          else            rel = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rel) begin
      rstn_d  = ch_rst_n_o | low;
      cnt_d   = '0;
      state_d = RELEASE;
`ifdef VPU_RST_SEQ_READY_WAIT_EN
      // Final channel still has to report ready before done.
      last_d  = low;
`else
      if (rest == '0) fin = 1'b1;
`endif
    end

    if (fin) begin
      done_d  = 1'b1;
      busy_d  = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HOLD;
      cnt_q        <= '0;
      mask_q       <= '1;
      ch_rst_n_o   <= '0;
      seq_busy_o   <= 1'b1;
      sw_rst_ack_o <= 1'b0;
      seq_done_o   <= 1'b0;
`ifdef VPU_RST_SEQ_READY_WAIT_EN
      seq_err_o    <= 1'b0;
      last_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      ch_rst_n_o   <= rstn_d;
      seq_busy_o   <= busy_d;
      sw_rst_ack_o <= ack_d;
      seq_done_o   <= done_d;
`ifdef VPU_RST_SEQ_READY_WAIT_EN
      seq_err_o    <= err_d;
      last_q       <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_vpu_reset_sequencer.sv
// tb_vpu_reset_sequencer
//   Directed bench for vpu_reset_sequencer in its default build (4 channels,
//   hold 16, stagger 4). Outputs are sampled 1 time unit after each rising edge.
module tb_vpu_reset_sequencer;

  localparam int NCH  = 4;
  localparam int HOLD = 16;
  localparam int STAG = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req = 1'b0;
  logic [NCH-1:0] mask = '0;
  logic           ack;
  logic [NCH-1:0] ch_rst_n;
  logic           busy;
  logic           done;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  vpu_reset_sequencer #(
    .NUM_CH        (NCH),
    .HOLD_CYCLES   (HOLD),
    .STAGGER_CYCLES(STAG),
    .WDOG_CYCLES   (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_rst_req_i(req),
    .ch_mask_i   (mask),
    .sw_rst_ack_o(ack),
    .ch_rst_n_o  (ch_rst_n),
    .seq_busy_o  (busy),
    .seq_done_o  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds rst for n edges; the last of them becomes edge 0 of the sequence.
  task automatic do_reset(input int unsigned n);
    rst = 1'b1;
    repeat (n) tick();
    check("rst_ch", ch_rst_n, 0);
    check("rst_busy", busy, 1);
    check("rst_ack", ack, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
  endtask

  // From edge 0 of a sequence with mask m: k-th masked channel rises at
  // HOLD + k*STAG, done pulses on the last rise, busy drops there.
  task automatic run_seq(input string name, input logic [NCH-1:0] m);
    int unsigned rise [NCH];
    int unsigned k = 0;
    int unsigned last;
    logic [NCH-1:0] exp_ch;
    for (int unsigned c = 0; c < NCH; c++) begin
      rise[c] = 0;
      if (m[c]) begin
        rise[c] = HOLD + k * STAG;
        k++;
      end
    end
    last = HOLD + (k - 1) * STAG;
    for (int unsigned e = 1; e <= last + 2; e++) begin
      tick();
      for (int unsigned c = 0; c < NCH; c++)
        exp_ch[c] = !m[c] || (e >= rise[c]);
      check({name, "_ch"}, ch_rst_n, exp_ch);
      check({name, "_busy"}, busy, (e < last) ? 1 : 0);
      check({name, "_done"}, done, (e == last) ? 1 : 0);
      check({name, "_ack"}, ack, 0);
    end
  endtask

  initial begin
    // T1: power-on sequence
    do_reset(5);
    run_seq("t1", 4'hF);

    // T2: soft reset of ch1/ch3
    req = 1'b1; mask = 4'b1010;
    tick();
    req = 1'b0; mask = '0;
    check("t2_ack", ack, 1);
    check("t2_ch0", ch_rst_n, 4'b0101);
    check("t2_busy0", busy, 1);
    run_seq("t2", 4'b1010);

    // T3: zero mask -> ack only; req left high one extra edge is ignored,
    // two edges after ack it counts as a new request
    req = 1'b1; mask = 4'b0000;
    tick();
    check("t3_ack", ack, 1);
    check("t3_ch", ch_rst_n, 4'hF);
    check("t3_busy", busy, 0);
    check("t3_done", done, 0);
    tick();
    check("t3_ack_gap", ack, 0);
    check("t3_ch_gap", ch_rst_n, 4'hF);
    tick();
    check("t3_ack_again", ack, 1);
    req = 1'b0;
    tick();
    check("t3_ack_end", ack, 0);
    check("t3_busy_end", busy, 0);
    check("t3_ch_end", ch_rst_n, 4'hF);

    // T4: request raised at edge 10 of a power-on sequence and held
    do_reset(2);
    for (int unsigned e = 1; e <= 10; e++) tick();
    req = 1'b1; mask = 4'b0100;
    for (int unsigned e = 11; e <= 28; e++) begin
      tick();
      check("t4_noack", ack, 0);
    end
    check("t4_done", done, 1);
    check("t4_ch_idle", ch_rst_n, 4'hF);
    tick();
    req = 1'b0; mask = '0;
    check("t4_ack", ack, 1);
    check("t4_ch_low", ch_rst_n, 4'b1011);
    check("t4_busy", busy, 1);
    run_seq("t4", 4'b0100);

    // T5: rst pulsed at edge 22 aborts and restarts the full sequence
    do_reset(3);
    for (int unsigned e = 1; e <= 21; e++) tick();
    check("t5_ch_pre", ch_rst_n, 4'b0011);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_ch_abort", ch_rst_n, 0);
    check("t5_busy_abort", busy, 1);
    check("t5_done_abort", done, 0);
    run_seq("t5", 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
